// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32 load/store initiator for four byte-lane data-memory banks.
// Splits word-crossing accesses into two bank accesses and aligns/extends load data.
module dmem_lsu #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned SPAN_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SECOND = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Access size in bytes (1/2/4); 0 marks an illegal funct3 for this direction.
    function automatic logic [2:0] access_size(input logic we, input logic [2:0] f3);
        case (f3)
            3'b000:  return 3'd1;
            3'b001:  return 3'd2;
            3'b010:  return 3'd4;
            3'b100:  return we ? 3'd0 : 3'd1;
            3'b101:  return we ? 3'd0 : 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic                we_q, unsigned_q, err_q, split_q;
    logic [1:0]          off_q;
    logic [2:0]          size_q;
    logic [DATA_W-1:0]   wdata_q, hold_q;
    logic [ADDR_W-1:0]   addr_q;

    logic                in_idle;
    logic [2:0]          req_size;
    logic [1:0]          req_off;
    logic                req_split;
    logic [1:0]          sel_off;
    logic [2:0]          sel_size;
    logic [DATA_W-1:0]   sel_wdata;
    logic [7:0]          size_mask;
    logic [7:0]          lane_mask;
    logic [SPAN_W-1:0]   lane_data;
    logic [SPAN_W-1:0]   rd_span;
    logic [DATA_W-1:0]   rd_low;
    logic [DATA_W-1:0]   load_ext;

    assign in_idle   = (state_q == S_IDLE);
    assign req_size  = access_size(req_we, req_funct3);
    assign req_off   = req_addr[1:0];
    assign req_split = (4'(req_off) + 4'(req_size)) > 4'd4;

    // Lane steering: the live request in IDLE, the captured one afterwards.
    // Bits [3:0] of the mask/data span target the first word, [7:4] the next word.
    assign sel_off   = in_idle ? req_off   : off_q;
    assign sel_size  = in_idle ? req_size  : size_q;
    assign sel_wdata = in_idle ? req_wdata : wdata_q;
    assign size_mask = (sel_size == 3'd4) ? 8'h0F :
                       (sel_size == 3'd2) ? 8'h03 :
                       (sel_size == 3'd1) ? 8'h01 : 8'h00;
    assign lane_mask = size_mask << sel_off;
    assign lane_data = SPAN_W'(sel_wdata) << {sel_off, 3'b000};

    // Load alignment: join held first word with the current bank word, shift down by offset.
    assign rd_span = split_q ? {mem_rdata, hold_q} : {{DATA_W{1'b0}}, mem_rdata};
    assign rd_low  = DATA_W'(rd_span >> {off_q, 3'b000});

    // Sign/zero extension of the aligned load bytes.
    always_comb begin
        load_ext = rd_low;
        case (size_q)
            3'd1:    load_ext = unsigned_q ? {24'h0, rd_low[7:0]}
                                           : {{24{rd_low[7]}}, rd_low[7:0]};
            3'd2:    load_ext = unsigned_q ? {16'h0, rd_low[15:0]}
                                           : {{16{rd_low[15]}}, rd_low[15:0]};
            default: load_ext = rd_low;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and bank/response outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_we     = 4'h0;
        mem_addr   = addr_q;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
                mem_wdata = lane_data[DATA_W-1:0];
                if (req_valid && req_we) mem_we = lane_mask[3:0];
                if (req_valid) state_d = req_split ? S_SECOND : S_RESP;
            end
            S_SECOND: begin
                mem_addr  = addr_q + ADDR_W'(4);
                mem_wdata = lane_data[SPAN_W-1:DATA_W];
                if (we_q) mem_we = lane_mask[7:4];
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!we_q && !err_q) resp_rdata = load_ext;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) mem_we = 4'h0;
    end

    // Request capture, second-word address step and first-word hold for split loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            split_q    <= 1'b0;
            off_q      <= 2'd0;
            size_q     <= 3'd0;
            wdata_q    <= '0;
            hold_q     <= '0;
            addr_q     <= '0;
        end else if (in_idle && req_valid) begin
            we_q       <= req_we;
            unsigned_q <= req_funct3[2];
            err_q      <= (req_size == 3'd0);
            split_q    <= req_split;
            off_q      <= req_off;
            size_q     <= req_size;
            wdata_q    <= req_wdata;
            addr_q     <= {req_addr[ADDR_W-1:2], 2'b00};
        end else if (state_q == S_SECOND) begin
            addr_q <= addr_q + ADDR_W'(4);
            if (!we_q) hold_q <= mem_rdata;
        end
    end

endmodule
